// File: rtl/riscv_pkg.sv
// Shared core-wide definitions used by the writeback stage and its scoreboard.
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  // Which result source most recently won a contested arbitration cycle.
  typedef enum logic {
    GRANT_ALU  = 1'b0,
    GRANT_LOAD = 1'b1
  } wb_grant_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Busy scoreboard for outstanding loads: one busy bit per architectural register
// plus a count of loads in flight that throttles further load issue.
module wb_scoreboard #(
  parameter int unsigned MAX_LOADS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ld_issue,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] ld_issue_rd,
  output logic                            ld_issue_ready,
  input  logic                            ld_accept,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] ld_rd,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] dec_rs1,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] dec_rs2,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] dec_rd,
  output logic                            busy_hazard
);
  import riscv_pkg::*;

  localparam logic [2:0] MaxLoads = 3'(MAX_LOADS);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [2:0]          pending_q, pending_d;
  logic                issue_fire;
  logic                pending_dec;

  // Issue throttling looks only at the registered count, never same-cycle returns.
  assign ld_issue_ready = (pending_q < MaxLoads);
  assign issue_fire     = ld_issue && ld_issue_ready;
  // A return with nothing pending is a protocol error; the counter must not wrap.
  assign pending_dec    = ld_accept && (pending_q != 3'd0);

  // Next-state busy vector: clear on return, then set on issue so set wins.
  always_comb begin
    busy_d = busy_q;
    if (ld_accept) begin
      busy_d[ld_rd] = 1'b0;
    end
    if (issue_fire) begin
      busy_d[ld_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Next-state pending count; simultaneous issue and return cancel out.
  always_comb begin
    pending_d = pending_q;
    if (issue_fire && !pending_dec) begin
      pending_d = pending_q + 3'd1;
    end else if (!issue_fire && pending_dec) begin
      pending_d = pending_q - 3'd1;
    end
  end

  // Scoreboard state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      pending_q <= 3'd0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

  // Any decode operand or destination that a load still owns must stall.
  assign busy_hazard = busy_q[dec_rs1] | busy_q[dec_rs2] | busy_q[dec_rd];

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: arbitrates ALU results against load returns, registers the
// winning write onto the register-file write port and raises decode hazards.
// Optional feature macro: WB_BYPASS_EN forwards the in-flight write to the
// decode operands instead of stalling on it.
module writeback_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MAX_LOADS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            alu_valid,
  output logic                            alu_ready,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]                 alu_data,
  input  logic                            ld_valid,
  output logic                            ld_ready,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]                 ld_data,
  input  logic                            ld_issue,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] ld_issue_rd,
  output logic                            ld_issue_ready,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] dec_rs1,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] dec_rs2,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] dec_rd,
  output logic                            hazard,
  input  logic [XLEN-1:0]                 rf_rd1,
  input  logic [XLEN-1:0]                 rf_rd2,
  output logic [XLEN-1:0]                 op_rd1,
  output logic [XLEN-1:0]                 op_rd2,
  output logic [riscv_pkg::REG_ADDR_W-1:0] addr3,
  output logic [XLEN-1:0]                 wdata3,
  output logic                            wen3
);
  import riscv_pkg::*;

  wb_grant_e             last_grant_q, last_grant_d;
  logic                  alu_fire, ld_fire, contested;
  logic [REG_ADDR_W-1:0] addr3_q, addr3_d;
  logic [XLEN-1:0]       wdata3_q, wdata3_d;
  logic                  wen3_q, wen3_d;
  logic                  busy_hazard;

  // Each ready depends only on the other side's valid and the fairness bit.
  always_comb begin
    alu_ready = !ld_valid || (last_grant_q == GRANT_LOAD);
    ld_ready  = !alu_valid || (last_grant_q == GRANT_ALU);
  end

  assign alu_fire  = alu_valid && alu_ready;
  assign ld_fire   = ld_valid && ld_ready;
  assign contested = alu_valid && ld_valid;

  // Next-state grant history and write-port contents.
  always_comb begin
    last_grant_d = last_grant_q;
    addr3_d      = addr3_q;
    wdata3_d     = wdata3_q;
    wen3_d       = 1'b0;
    if (contested) begin
      last_grant_d = ld_fire ? GRANT_LOAD : GRANT_ALU;
    end
    if (ld_fire) begin
      addr3_d  = ld_rd;
      wdata3_d = ld_data;
      wen3_d   = (ld_rd != '0);
    end else if (alu_fire) begin
      addr3_d  = alu_rd;
      wdata3_d = alu_data;
      wen3_d   = (alu_rd != '0);
    end
  end

  // Arbitration and write-port registers; reset drops any in-flight write.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GRANT_ALU;
      addr3_q      <= '0;
      wdata3_q     <= '0;
      wen3_q       <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      addr3_q      <= addr3_d;
      wdata3_q     <= wdata3_d;
      wen3_q       <= wen3_d;
    end
  end

  assign addr3  = addr3_q;
  assign wdata3 = wdata3_q;
  assign wen3   = wen3_q;

  wb_scoreboard #(
    .MAX_LOADS (MAX_LOADS)
  ) u_scoreboard (
    .clk            (clk),
    .rst            (rst),
    .ld_issue       (ld_issue),
    .ld_issue_rd    (ld_issue_rd),
    .ld_issue_ready (ld_issue_ready),
    .ld_accept      (ld_fire),
    .ld_rd          (ld_rd),
    .dec_rs1        (dec_rs1),
    .dec_rs2        (dec_rs2),
    .dec_rd         (dec_rd),
    .busy_hazard    (busy_hazard)
  );

`ifdef WB_BYPASS_EN
  // Forward the write still in flight to the register file; no stall needed.
  always_comb begin
    op_rd1 = rf_rd1;
    op_rd2 = rf_rd2;
    if (wen3_q && (addr3_q == dec_rs1) && (addr3_q != '0)) begin
      op_rd1 = wdata3_q;
    end
    if (wen3_q && (addr3_q == dec_rs2) && (addr3_q != '0)) begin
      op_rd2 = wdata3_q;
    end
    hazard = busy_hazard;
  end
`else
  // Without forwarding, a source matching the in-flight write stalls one cycle.
  always_comb begin
    op_rd1 = rf_rd1;
    op_rd2 = rf_rd2;
    hazard = busy_hazard |
             (wen3_q && (addr3_q != '0) &&
              ((addr3_q == dec_rs1) || (addr3_q == dec_rs2)));
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage; expectations follow the
// WB_BYPASS_EN setting of the build.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_issue, ld_issue_ready;
  logic [4:0]  ld_issue_rd;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        hazard;
  logic [31:0] rf_rd1, rf_rd2, op_rd1, op_rd2;
  logic [4:0]  addr3;
  logic [31:0] wdata3;
  logic        wen3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_stage #(
    .XLEN      (32),
    .MAX_LOADS (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .ld_valid       (ld_valid),
    .ld_ready       (ld_ready),
    .ld_rd          (ld_rd),
    .ld_data        (ld_data),
    .ld_issue       (ld_issue),
    .ld_issue_rd    (ld_issue_rd),
    .ld_issue_ready (ld_issue_ready),
    .dec_rs1        (dec_rs1),
    .dec_rs2        (dec_rs2),
    .dec_rd         (dec_rd),
    .hazard         (hazard),
    .rf_rd1         (rf_rd1),
    .rf_rd2         (rf_rd2),
    .op_rd1         (op_rd1),
    .op_rd2         (op_rd2),
    .addr3          (addr3),
    .wdata3         (wdata3),
    .wen3           (wen3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_data    = '0;
    ld_valid    = 1'b0;
    ld_rd       = '0;
    ld_data     = '0;
    ld_issue    = 1'b0;
    ld_issue_rd = '0;
    dec_rs1     = '0;
    dec_rs2     = '0;
    dec_rd      = '0;
    rf_rd1      = '0;
    rf_rd2      = '0;
  endtask

  // Inputs change on the falling edge; checks happen 1ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // ALU writes must never target a register a load still owns.
  always begin
    @(negedge clk);
    #3;
    if (!rst && alu_valid && alu_ready && alu_rd != 5'd0) begin
      check("alu_rd_not_busy", 32'(dut.u_scoreboard.busy_q[alu_rd]), 32'd0);
    end
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    do_reset();
    #1;
    check("rst_wen3", 32'(wen3), 32'd0);
    check("rst_addr3", 32'(addr3), 32'd0);
    check("rst_wdata3", wdata3, 32'd0);
    check("rst_hazard", 32'(hazard), 32'd0);
    check("rst_issue_ready", 32'(ld_issue_ready), 32'd1);
    check("rst_alu_ready", 32'(alu_ready), 32'd1);
    check("rst_ld_ready", 32'(ld_ready), 32'd1);

    // Single ALU write.
    next_cycle();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1 check("alu_ready_n", 32'(alu_ready), 32'd1);
    next_cycle();
    alu_valid = 1'b0;
    #1;
    check("alu_wen3", 32'(wen3), 32'd1);
    check("alu_addr3", 32'(addr3), 32'd5);
    check("alu_wdata3", wdata3, 32'hDEADBEEF);
    check("alu_ready_n1", 32'(alu_ready), 32'd1);
    next_cycle();
    #1;
    check("idle_wen3", 32'(wen3), 32'd0);
    check("idle_addr3_hold", 32'(addr3), 32'd5);
    check("idle_wdata3_hold", wdata3, 32'hDEADBEEF);

    // Contested arbitration from reset: LOAD, ALU, LOAD.
    do_reset();
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h33;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
    #1;
    check("arb1_ld_ready", 32'(ld_ready), 32'd1);
    check("arb1_alu_ready", 32'(alu_ready), 32'd0);
    next_cycle();
    #1;
    check("arb2_ld_ready", 32'(ld_ready), 32'd0);
    check("arb2_alu_ready", 32'(alu_ready), 32'd1);
    check("arb1_addr3", 32'(addr3), 32'd3);
    check("arb1_wdata3", wdata3, 32'h33);
    next_cycle();
    #1;
    check("arb3_ld_ready", 32'(ld_ready), 32'd1);
    check("arb3_alu_ready", 32'(alu_ready), 32'd0);
    check("arb2_addr3", 32'(addr3), 32'd4);
    check("arb2_wdata3", wdata3, 32'h44);
    next_cycle();
    alu_valid = 1'b0; ld_valid = 1'b0;
    #1;
    check("arb3_addr3", 32'(addr3), 32'd3);
    check("arb3_wen3", 32'(wen3), 32'd1);

    // Load issue throttling.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      ld_issue = 1'b1; ld_issue_rd = 5'(i);
      #1 check($sformatf("issue_ready_x%0d", i), 32'(ld_issue_ready), 32'd1);
      next_cycle();
    end
    ld_issue = 1'b1; ld_issue_rd = 5'd5;
    #1 check("issue_full", 32'(ld_issue_ready), 32'd0);
    next_cycle();
    ld_issue = 1'b0;
    dec_rd = 5'd5;
    #1;
    check("fifth_ignored_busy", 32'(hazard), 32'd0);
    check("fifth_ignored_ready", 32'(ld_issue_ready), 32'd0);
    dec_rd = 5'd2;
    #1 check("x2_busy", 32'(hazard), 32'd1);
    ld_valid = 1'b1; ld_rd = 5'd2; ld_data = 32'h22;
    #1 check("x2_ld_ready", 32'(ld_ready), 32'd1);
    next_cycle();
    ld_valid = 1'b0;
    #1;
    check("x2_issue_ready", 32'(ld_issue_ready), 32'd1);
    check("x2_busy_clear", 32'(hazard), 32'd0);
    check("x2_wen3", 32'(wen3), 32'd1);
    check("x2_wdata3", wdata3, 32'h22);

    // RAW hazard on a pending load; same-cycle issue and return.
    do_reset();
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    next_cycle();
    ld_issue = 1'b0; dec_rs2 = 5'd7;
    #1 check("x7_hazard_a", 32'(hazard), 32'd1);
    next_cycle();
    #1 check("x7_hazard_b", 32'(hazard), 32'd1);
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h77;
    #1 check("x7_hazard_ret", 32'(hazard), 32'd1);
    next_cycle();
    ld_issue = 1'b0; ld_valid = 1'b0;
    dec_rs2 = 5'd0; dec_rd = 5'd7;
    #1;
    check("x7_set_wins", 32'(hazard), 32'd1);
    check("x7_wen3", 32'(wen3), 32'd1);
    ld_valid = 1'b1;
    next_cycle();
    ld_valid = 1'b0;
    next_cycle();
    #1;
    check("x7_cleared", 32'(hazard), 32'd0);
    check("x7_issue_ready", 32'(ld_issue_ready), 32'd1);

    // Writes and issues to x0.
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h99;
    #1 check("x0_alu_ready", 32'(alu_ready), 32'd1);
    next_cycle();
    alu_valid = 1'b0;
    ld_issue = 1'b1; ld_issue_rd = 5'd0;
    #1;
    check("x0_wen3", 32'(wen3), 32'd0);
    check("x0_wdata3", wdata3, 32'h99);
    next_cycle();
    ld_issue = 1'b0;
    #1 check("x0_no_hazard", 32'(hazard), 32'd0);

    // In-flight write seen by decode in the following cycle.
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h55;
    next_cycle();
    alu_valid = 1'b0;
    dec_rs1 = 5'd9; rf_rd1 = 32'h11; rf_rd2 = 32'h22;
    #1;
`ifdef WB_BYPASS_EN
    check("byp_op_rd1", op_rd1, 32'h55);
    check("byp_hazard", 32'(hazard), 32'd0);
`else
    check("nobyp_op_rd1", op_rd1, 32'h11);
    check("nobyp_hazard", 32'(hazard), 32'd1);
`endif
    check("op_rd2_passthru", op_rd2, 32'h22);
    next_cycle();
    #1;
    check("after_hazard", 32'(hazard), 32'd0);
    check("after_op_rd1", op_rd1, 32'h11);

    // Mid-operation reset drops the in-flight write and scoreboard state.
    ld_issue = 1'b1; ld_issue_rd = 5'd12;
    alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'hABCD;
    next_cycle();
    do_reset();
    dec_rd = 5'd12;
    #1;
    check("midrst_wen3", 32'(wen3), 32'd0);
    check("midrst_busy", 32'(hazard), 32'd0);

    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
